// File: rtl/arbitro_rr_4a1_pkg.sv
// Switch-wide definitions shared by the ingress/egress arbiters: system states and default word width.
package arbitro_rr_4a1_pkg;

   typedef enum logic [3:0] {
      ST_RESET  = 4'b0001,
      ST_INIT   = 4'b0010,
      ST_IDLE   = 4'b0100,
      ST_ACTIVE = 4'b1000
   } sys_state_e;

   localparam int DEFAULT_BW = 6;

   // Next requester index in the ring, wrapping 3 -> 0.
   function automatic logic [1:0] rr_inc(input logic [1:0] p);
      return p + 2'd1;
   endfunction

endpackage

// File: rtl/arbitro_rr_4a1_picker.sv
// Combinational 4-way round-robin picker: first eligible requester scanning from ptr upward (mod 4).
// Zero latency; no state, so it is shared with the 1-to-4 distribution arbiter.
module rr_picker_4
   import arbitro_rr_4a1_pkg::*;
(
   input  logic [1:0] ptr,
   input  logic [3:0] eligible,
   output logic [1:0] grant,
   output logic       any
);

   logic [1:0] idx;

   always_comb begin
      grant = ptr;
      any   = 1'b0;
      idx   = ptr;
      for (int i = 0; i < 4; i++) begin
         if (!any && eligible[idx]) begin
            grant = idx;
            any   = 1'b1;
         end
         idx = rr_inc(idx);
      end
   end

endmodule

// File: rtl/arbitro_rr_4a1.sv
// 4-to-1 round-robin drain of four input FIFOs into one output FIFO; pop in cycle N, push in N+1.
// almost_full or leaving ST_ACTIVE blocks new pops only; the word already in flight is always pushed.
module arbitro_rr_4a1
   import arbitro_rr_4a1_pkg::*;
#(
   parameter int BW      = DEFAULT_BW,
   parameter int QUANTUM = 1
)
(
   input  logic          clk,
   input  logic          reset,
   input  logic [3:0]    state,
   input  logic          empty0,
   input  logic          empty1,
   input  logic          empty2,
   input  logic          empty3,
   input  logic [BW-1:0] data_in0,
   input  logic [BW-1:0] data_in1,
   input  logic [BW-1:0] data_in2,
   input  logic [BW-1:0] data_in3,
   input  logic          almost_full,
   output logic          pop0,
   output logic          pop1,
   output logic          pop2,
   output logic          pop3,
   output logic          push,
   output logic [BW-1:0] data_out,
   output logic          idle
);

   localparam int CW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;

   logic [1:0]    ptr_q, ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pend_q;
   logic [1:0]    sel_q, sel_d;
   logic          idle_q;

   logic [3:0]    eligible;
   logic [1:0]    grant;
   logic          any;
   logic          go;

   assign eligible = ~{empty3, empty2, empty1, empty0};

   rr_picker_4 u_picker (
      .ptr      (ptr_q),
      .eligible (eligible),
      .grant    (grant),
      .any      (any)
   );

   assign go = (state == ST_ACTIVE) & ~almost_full & ~reset & any;

   assign pop0 = go & (grant == 2'd0);
   assign pop1 = go & (grant == 2'd1);
   assign pop2 = go & (grant == 2'd2);
   assign pop3 = go & (grant == 2'd3);

   // cnt tracks how long ptr has held on its current owner; ptr leaves once the quantum is used up.
   always_comb begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      if (go) begin
         if ((grant == ptr_q) && (int'(cnt_q) < QUANTUM - 1)) begin
            cnt_d = cnt_q + CW'(1);
         end else if ((grant != ptr_q) && (QUANTUM > 1)) begin
            ptr_d = grant;
            cnt_d = CW'(1);
         end else begin
            ptr_d = rr_inc(grant);
            cnt_d = '0;
         end
      end
   end

   // Select only moves on a real grant so data_out stays quiet between pushes.
   assign sel_d = go ? grant : sel_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q  <= 2'd0;
         cnt_q  <= '0;
         pend_q <= 1'b0;
         sel_q  <= 2'd0;
         idle_q <= 1'b1;
      end else begin
         ptr_q  <= ptr_d;
         cnt_q  <= cnt_d;
         pend_q <= go;
         sel_q  <= sel_d;
         idle_q <= ~go & ~pend_q;
      end
   end

   always_comb begin
      data_out = data_in0;
      case (sel_q)
         2'd0:    data_out = data_in0;
         2'd1:    data_out = data_in1;
         2'd2:    data_out = data_in2;
         default: data_out = data_in3;
      endcase
   end

   assign push = pend_q;
   assign idle = idle_q;

endmodule

// File: tb/tb_arbitro_rr_4a1.sv
// Drives a QUANTUM=1 and a QUANTUM=3 arbiter from the same control stimulus, each with its own FIFO model.
module tb_arbitro_rr_4a1;
   import arbitro_rr_4a1_pkg::*;

   localparam int BW = 6;

   logic          clk = 1'b0;
   logic          reset;
   logic [3:0]    state;
   logic          af;
   logic          emp  [2][4];
   logic [BW-1:0] din  [2][4];
   logic          pop  [2][4];
   logic          push [2];
   logic [BW-1:0] dout [2];
   logic          idle [2];

   always #5 clk = ~clk;

   arbitro_rr_4a1 #(.BW(BW), .QUANTUM(1)) u_q1 (
      .clk(clk), .reset(reset), .state(state),
      .empty0(emp[0][0]), .empty1(emp[0][1]), .empty2(emp[0][2]), .empty3(emp[0][3]),
      .data_in0(din[0][0]), .data_in1(din[0][1]), .data_in2(din[0][2]), .data_in3(din[0][3]),
      .almost_full(af),
      .pop0(pop[0][0]), .pop1(pop[0][1]), .pop2(pop[0][2]), .pop3(pop[0][3]),
      .push(push[0]), .data_out(dout[0]), .idle(idle[0])
   );

   arbitro_rr_4a1 #(.BW(BW), .QUANTUM(3)) u_q3 (
      .clk(clk), .reset(reset), .state(state),
      .empty0(emp[1][0]), .empty1(emp[1][1]), .empty2(emp[1][2]), .empty3(emp[1][3]),
      .data_in0(din[1][0]), .data_in1(din[1][1]), .data_in2(din[1][2]), .data_in3(din[1][3]),
      .almost_full(af),
      .pop0(pop[1][0]), .pop1(pop[1][1]), .pop2(pop[1][2]), .pop3(pop[1][3]),
      .push(push[1]), .data_out(dout[1]), .idle(idle[1])
   );

   int checks = 0;
   int errors = 0;

   // Reference state: FIFO contents as queues, and per-instance ring pointer/quantum usage.
   logic [BW-1:0] fq [8][$];
   int            qv    [2] = '{1, 3};
   int            mptr  [2];
   int            mcnt  [2];
   bit            mpend [2];
   bit            midle [2];
   logic [BW-1:0] mword [2];
   logic [3:0]    popv  [2];
   int            glog0 [$];
   int            glog1 [$];
   int            wseq = 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic refresh();
      for (int i = 0; i < 2; i++)
         for (int k = 0; k < 4; k++)
            emp[i][k] = (fq[i*4+k].size() == 0);
   endtask

   task automatic add_word(input int q);
      fq[q].push_back(BW'(wseq));
      wseq++;
   endtask

   task automatic step();
      bit go [2];
      int g  [2];
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         go[i] = 1'b0;
         g[i]  = 0;
         if (!reset && state == ST_ACTIVE && !af) begin
            for (int j = 0; j < 4; j++) begin
               int k = (mptr[i] + j) % 4;
               if (!go[i] && !emp[i][k]) begin
                  go[i] = 1'b1;
                  g[i]  = k;
               end
            end
         end
         popv[i] = {pop[i][3], pop[i][2], pop[i][1], pop[i][0]};
         for (int k = 0; k < 4; k++)
            chk($sformatf("q%0d pop%0d", qv[i], k), pop[i][k], (go[i] && g[i] == k));
         chk($sformatf("q%0d push", qv[i]), push[i], mpend[i]);
         if (mpend[i]) chk($sformatf("q%0d data_out", qv[i]), dout[i], mword[i]);
         chk($sformatf("q%0d idle", qv[i]), idle[i], midle[i]);
         for (int k = 0; k < 4; k++)
            if (pop[i][k]) begin
               if (i == 0) glog0.push_back(k); else glog1.push_back(k);
            end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            mptr[i] = 0; mcnt[i] = 0; mpend[i] = 1'b0; midle[i] = 1'b1;
            for (int k = 0; k < 4; k++) fq[i*4+k].delete();
         end else begin
            midle[i] = !go[i] && !mpend[i];
            mpend[i] = go[i];
            if (go[i]) begin
               mword[i] = fq[i*4+g[i]].pop_front();
               din[i][g[i]] = mword[i];
               if (g[i] == mptr[i] && mcnt[i] < qv[i] - 1) begin
                  mcnt[i]++;
               end else if (g[i] != mptr[i] && qv[i] > 1) begin
                  mptr[i] = g[i]; mcnt[i] = 1;
               end else begin
                  mptr[i] = (g[i] + 1) % 4; mcnt[i] = 0;
               end
            end
         end
      end
      refresh();
   endtask

   task automatic fill_all(input int n);
      for (int q = 0; q < 8; q++)
         for (int w = 0; w < n; w++) add_word(q);
      refresh();
   endtask

   typedef struct {
      bit         rst;
      logic [3:0] st;
      bit         af;
      logic [3:0] mask;
      logic [3:0] p1;
      logic [3:0] p3;
   } vec_t;

   vec_t vt [13];
   int   e_q1 [5];
   int   e_q3 [12];
   logic [3:0] others [3];

   initial begin
      vt[0]  = '{0, ST_ACTIVE, 0, 4'b1111, 4'b0001, 4'b0001};
      vt[1]  = '{0, ST_ACTIVE, 0, 4'b1111, 4'b0010, 4'b0001};
      vt[2]  = '{0, ST_ACTIVE, 0, 4'b0100, 4'b0100, 4'b0100};
      vt[3]  = '{0, ST_ACTIVE, 0, 4'b0100, 4'b0100, 4'b0100};
      vt[4]  = '{0, ST_ACTIVE, 1, 4'b1111, 4'b0000, 4'b0000};
      vt[5]  = '{0, ST_IDLE,   0, 4'b1111, 4'b0000, 4'b0000};
      vt[6]  = '{0, ST_ACTIVE, 0, 4'b0000, 4'b0000, 4'b0000};
      vt[7]  = '{0, ST_ACTIVE, 0, 4'b1001, 4'b1000, 4'b1000};
      vt[8]  = '{0, ST_ACTIVE, 0, 4'b1011, 4'b0001, 4'b1000};
      vt[9]  = '{0, ST_ACTIVE, 0, 4'b1011, 4'b0010, 4'b1000};
      vt[10] = '{0, ST_ACTIVE, 0, 4'b1010, 4'b1000, 4'b0010};
      vt[11] = '{1, ST_ACTIVE, 0, 4'b1111, 4'b0000, 4'b0000};
      vt[12] = '{0, ST_ACTIVE, 0, 4'b0010, 4'b0010, 4'b0010};
      e_q1 = '{0, 1, 2, 3, 0};
      e_q3 = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
      others = '{ST_RESET, ST_INIT, ST_IDLE};

      for (int i = 0; i < 2; i++)
         for (int k = 0; k < 4; k++) din[i][k] = BW'(8 + k + 16 * i);
      reset = 1'b1; state = ST_RESET; af = 1'b0;
      for (int i = 0; i < 2; i++) begin
         mptr[i] = 0; mcnt[i] = 0; mpend[i] = 1'b0; midle[i] = 1'b1; mword[i] = '0;
      end
      refresh();
      repeat (2) @(posedge clk);
      #1;

      // Reset values, then ST_ACTIVE with nothing queued.
      step();
      reset = 1'b0; state = ST_ACTIVE;
      chk("rst q1 data_out", dout[0], din[0][0]);
      chk("rst q3 data_out", dout[1], din[1][0]);
      step();

      // Hand-computed arbitration vectors (ptr starts at 0 for both instances).
      foreach (vt[v]) begin
         reset = vt[v].rst; state = vt[v].st; af = vt[v].af;
         for (int i = 0; i < 2; i++)
            for (int k = 0; k < 4; k++) begin
               if (!vt[v].mask[k]) fq[i*4+k].delete();
               else if (fq[i*4+k].size() == 0) add_word(i*4+k);
            end
         refresh();
         step();
         chk($sformatf("vec%0d q1 pops", v), popv[0], vt[v].p1);
         chk($sformatf("vec%0d q3 pops", v), popv[1], vt[v].p3);
      end
      reset = 1'b0;

      // Fresh start, all FIFOs full: grant order per quantum.
      reset = 1'b1; step(); reset = 1'b0;
      fill_all(6);
      glog0.delete(); glog1.delete();
      repeat (12) step();
      for (int n = 0; n < 5; n++)
         chk($sformatf("q1 order%0d", n), (n < glog0.size()) ? glog0[n] : -1, e_q1[n]);
      for (int n = 0; n < 12; n++)
         chk($sformatf("q3 order%0d", n), (n < glog1.size()) ? glog1[n] : -1, e_q3[n]);

      // almost_full while streaming, then resume.
      af = 1'b1; repeat (3) step();
      af = 1'b0; repeat (2) step();

      // Drop out of ST_ACTIVE mid-stream.
      state = ST_IDLE; repeat (3) step();
      chk("q1 idle after leave", idle[0], 1'b1);
      state = ST_ACTIVE; repeat (2) step();

      // Reset the cycle after a pop; first grant afterwards must be FIFO 0.
      reset = 1'b1; step(); reset = 1'b0;
      step();
      fill_all(2);
      glog0.delete(); glog1.delete();
      step();
      chk("q1 first after reset", (glog0.size() > 0) ? glog0[0] : -1, 0);
      chk("q3 first after reset", (glog1.size() > 0) ? glog1[0] : -1, 0);
      repeat (10) step();

      // Randomized control and refill against the reference model.
      for (int c = 0; c < 1500; c++) begin
         reset = ($urandom_range(0, 99) < 2);
         state = ($urandom_range(0, 99) < 85) ? ST_ACTIVE : others[$urandom_range(0, 2)];
         af    = ($urandom_range(0, 99) < 20);
         for (int q = 0; q < 8; q++)
            if ($urandom_range(0, 99) < 25) add_word(q);
         refresh();
         step();
      end
      reset = 1'b0; state = ST_ACTIVE; af = 1'b0;
      repeat (40) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
